// File: rtl/rob_dispatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_dispatch_ctrl_pkg
// Description : Shared widths, the dispatch lane record and helper functions
//               used by the dispatch sequencer and its ROB interface.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_dispatch_ctrl_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int ROB_ADDR_WIDTH       = 6;
    localparam int PHYS_REGS_ADDR_WIDTH = 7;
    localparam int DISPATCH_ADDR_WIDTH  = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;
    localparam int GROUP_DEPTH_DEFAULT  = 2;
    localparam int POP_WIDTH            = $clog2(DISPATCH_WIDTH + 1);

    typedef struct packed {
        logic                            valid;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
        logic [4:0]                      arch_rd;
        logic                            is_branch_instr;
        logic                            pred_taken;
        logic [12:0]                     br_offset;
        logic [31:0]                     pc;
        logic [31:0]                     instr;
    } dispatch_lane_t;

    function automatic logic [POP_WIDTH-1:0] popcount_lanes(input logic [DISPATCH_WIDTH-1:0] v);
        logic [POP_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            n = n + POP_WIDTH'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : robDispatchIf
// Description : ROB dispatch port: per-lane enables and fields toward the ROB,
//               allocated tags, banks and the full flag back.
// Revision    : 1.0 - initial release
// ============================================================================
interface robDispatchIf;
    import rob_dispatch_ctrl_pkg::*;

    logic [DISPATCH_WIDTH-1:0]                          en;
    dispatch_lane_t [DISPATCH_WIDTH-1:0]                lane;
    logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]      rob_addr;
    logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0] bank_addr;
    logic                                               full;

    modport out (output en, output lane, input rob_addr, input bank_addr, input full);
    modport in  (input en, input lane, output rob_addr, output bank_addr, output full);

endinterface
`default_nettype wire

// File: rtl/rob_dispatch_ctrl_group_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_group_fifo
// Description : Circular buffer of dispatch groups with occupancy count and a
//               single-cycle flush that empties it.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_group_fifo
    import rob_dispatch_ctrl_pkg::*;
#(
    parameter int GROUP_DEPTH = GROUP_DEPTH_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic                                 push_i,
    input  logic                                 pop_i,
    input  dispatch_lane_t [DISPATCH_WIDTH-1:0]  wr_group_i,
    output dispatch_lane_t [DISPATCH_WIDTH-1:0]  head_group_o,
    output logic [$clog2(GROUP_DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = (GROUP_DEPTH > 1) ? $clog2(GROUP_DEPTH) : 1;
    localparam int CNT_W = $clog2(GROUP_DEPTH + 1);

    dispatch_lane_t [DISPATCH_WIDTH-1:0] mem_q [GROUP_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Depth is a power of two, so pointer overflow is the wrap.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PTR_W'(1);
            if (pop_i)  head_d = head_q + PTR_W'(1);
            if (push_i && !pop_i) count_d = count_q + CNT_W'(1);
            if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < GROUP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i && !flush_i) begin
                mem_q[tail_q] <= wr_group_i;
            end
        end
    end

    assign head_group_o = mem_q[head_q];
    assign count_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/rob_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rob_dispatch_ctrl
// Description : Buffers decode groups and presents the head group to the ROB,
//               returning allocated tags. Define ROB_DISPATCH_PERF_EN to add
//               the stall / dispatched-lane performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_dispatch_ctrl
    import rob_dispatch_ctrl_pkg::*;
#(
    parameter int GROUP_DEPTH = GROUP_DEPTH_DEFAULT
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 flush,
    input  logic                                                 dec_valid,
    output logic                                                 dec_ready,
    input  dispatch_lane_t [DISPATCH_WIDTH-1:0]                  dec_lane,
    robDispatchIf.out                                            rob,
    output logic [DISPATCH_WIDTH-1:0]                            disp_valid,
    output logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]        disp_rob_addr,
    output logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]   disp_bank_addr
`ifdef ROB_DISPATCH_PERF_EN
    ,
    output logic [31:0]                                          perf_stall_cycles,
    output logic [31:0]                                          perf_dispatched
`endif
);

    localparam int CNT_W = $clog2(GROUP_DEPTH + 1);

    logic [CNT_W-1:0]                    count;
    dispatch_lane_t [DISPATCH_WIDTH-1:0] head_group;
    logic                                head_valid;
    logic                                push;
    logic                                fire;
    logic [DISPATCH_WIDTH-1:0]           rob_en;

    // Ready depends on registered occupancy only; a same-cycle pop never frees a slot.
    assign dec_ready  = (count != CNT_W'(GROUP_DEPTH));
    assign head_valid = (count != '0);
    assign push       = dec_valid && dec_ready && !flush;
    assign fire       = head_valid && !rob.full && !flush;

    dispatch_group_fifo #(
        .GROUP_DEPTH (GROUP_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .push_i       (push),
        .pop_i        (fire),
        .wr_group_i   (dec_lane),
        .head_group_o (head_group),
        .count_o      (count)
    );

    always_comb begin
        rob_en = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            rob_en[i] = fire && head_group[i].valid;
        end
    end

    assign rob.en         = rob_en;
    assign rob.lane       = head_group;
    assign disp_valid     = rob_en;
    assign disp_rob_addr  = rob.rob_addr;
    assign disp_bank_addr = rob.bank_addr;

`ifdef ROB_DISPATCH_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] disp_cnt_q, disp_cnt_d;
    logic [32:0] disp_sum;

    always_comb begin
        stall_d = stall_q;
        if (head_valid && rob.full && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        disp_sum   = {1'b0, disp_cnt_q} + 33'(popcount_lanes(rob_en));
        disp_cnt_d = disp_sum[32] ? '1 : disp_sum[31:0];
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q    <= '0;
            disp_cnt_q <= '0;
        end else begin
            stall_q    <= stall_d;
            disp_cnt_q <= disp_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_dispatched   = disp_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_dispatch_ctrl
// Description : Self-checking bench: directed vector table, hand sequences and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_dispatch_ctrl;
    import rob_dispatch_ctrl_pkg::*;

    localparam int DEPTH = GROUP_DEPTH_DEFAULT;

    typedef dispatch_lane_t [DISPATCH_WIDTH-1:0] grp_t;

    typedef struct {
        logic        dv;
        logic [1:0]  lv;
        logic [31:0] pc;
        logic        full;
        logic        fl;
        logic        exp_ready;
        logic [1:0]  exp_en;
        logic        chk_pc;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic dec_valid;
    logic dec_ready;
    grp_t dec_lane;
    logic [DISPATCH_WIDTH-1:0]                          disp_valid;
    logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]      disp_rob_addr;
    logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0] disp_bank_addr;
`ifdef ROB_DISPATCH_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_dispatched;
`endif

    robDispatchIf rob_if ();

    int   n_cmp  = 0;
    int   n_fail = 0;
    grp_t model_q[$];
    vec_t vecs[16];

    always #5 clk = ~clk;

    rob_dispatch_ctrl #(
        .GROUP_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .dec_valid         (dec_valid),
        .dec_ready         (dec_ready),
        .dec_lane          (dec_lane),
        .rob               (rob_if),
        .disp_valid        (disp_valid),
        .disp_rob_addr     (disp_rob_addr),
        .disp_bank_addr    (disp_bank_addr)
`ifdef ROB_DISPATCH_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_dispatched   (perf_dispatched)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic grp_t mk_grp(input logic [31:0] pc, input logic [1:0] lv);
        grp_t g;
        g = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            g[i].valid   = lv[i];
            g[i].pc      = pc + 32'(4 * i);
            g[i].instr   = (i == 0) ? 32'h0000_0013 : 32'h0010_0093;
            g[i].phys_rd = PHYS_REGS_ADDR_WIDTH'(i + 1);
            g[i].arch_rd = 5'(i + 3);
        end
        return g;
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        flush      = 1'b0;
        dec_valid  = 1'b0;
        dec_lane   = '0;
        rob_if.full      = 1'b0;
        rob_if.rob_addr  = '0;
        rob_if.bank_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        model_q.delete();
    endtask

    // Reference: a plain queue of groups, at most DEPTH deep.
    task automatic rand_cycle(input int cyc);
        grp_t g;
        logic fu, fl, dv, hv, rdy;
        logic [1:0] en_exp;
        logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0] ra;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            g[i]                 = '0;
            g[i].valid           = 1'($urandom);
            g[i].phys_rd         = PHYS_REGS_ADDR_WIDTH'($urandom);
            g[i].arch_rd         = 5'($urandom);
            g[i].is_branch_instr = 1'($urandom);
            g[i].pred_taken      = 1'($urandom);
            g[i].br_offset       = 13'($urandom);
            g[i].pc              = $urandom;
            g[i].instr           = $urandom;
            ra[i]                = ROB_ADDR_WIDTH'($urandom);
        end
        dv = 1'($urandom);
        fu = ($urandom_range(0, 3) == 0);
        fl = ($urandom_range(0, 15) == 0);
        dec_valid        = dv;
        dec_lane         = g;
        rob_if.full      = fu;
        flush            = fl;
        rob_if.rob_addr  = ra;
        rob_if.bank_addr = '0;
        #1;
        hv     = (model_q.size() != 0);
        rdy    = (model_q.size() != DEPTH);
        en_exp = '0;
        if (hv) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                en_exp[i] = model_q[0][i].valid && !fu && !fl;
            end
        end
        check($sformatf("rnd%0d_ready", cyc), 64'(dec_ready), 64'(rdy));
        check($sformatf("rnd%0d_en", cyc), 64'(rob_if.en), 64'(en_exp));
        check($sformatf("rnd%0d_disp_valid", cyc), 64'(disp_valid), 64'(en_exp));
        check($sformatf("rnd%0d_tag", cyc), 64'(disp_rob_addr), 64'(ra));
        if (hv) begin
            check($sformatf("rnd%0d_lane0", cyc), {rob_if.lane[0].pc, rob_if.lane[0].instr},
                  {model_q[0][0].pc, model_q[0][0].instr});
            check($sformatf("rnd%0d_lane1", cyc), {rob_if.lane[1].pc, rob_if.lane[1].instr},
                  {model_q[0][1].pc, model_q[0][1].instr});
        end
        if (fl) begin
            model_q.delete();
        end else begin
            if (hv && !fu) void'(model_q.pop_front());
            if (dv && rdy) model_q.push_back(g);
        end
        tick();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b11, 32'h200, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 2'b11, 32'h300, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h200};
        vecs[2]  = '{1'b1, 2'b11, 32'h400, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h200};
        vecs[3]  = '{1'b0, 2'b11, 32'h0,   1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 32'h200};
        vecs[4]  = '{1'b0, 2'b11, 32'h0,   1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 32'h300};
        vecs[5]  = '{1'b0, 2'b11, 32'h0,   1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 2'b01, 32'h500, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 2'b00, 32'h0,   1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 32'h500};
        vecs[8]  = '{1'b1, 2'b00, 32'h600, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 2'b00, 32'h0,   1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h600};
        vecs[10] = '{1'b0, 2'b00, 32'h0,   1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 2'b11, 32'h700, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 2'b11, 32'h800, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h700};
        vecs[13] = '{1'b1, 2'b11, 32'h900, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h700};
        vecs[14] = '{1'b0, 2'b11, 32'h0,   1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 2'b11, 32'h0,   1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0};

        do_reset();
        #1;
        check("rst_ready", 64'(dec_ready), 64'(1));
        check("rst_en", 64'(rob_if.en), 64'(0));
        check("rst_disp_valid", 64'(disp_valid), 64'(0));
        check("rst_fields", {rob_if.lane[0].pc, rob_if.lane[1].pc}, 64'(0));

        // Single group: no bypass, then dispatch with tags {5,6} on the next cycle.
        dec_valid        = 1'b1;
        dec_lane         = mk_grp(32'h100, 2'b11);
        rob_if.rob_addr  = {6'd6, 6'd5};
        rob_if.bank_addr = {1'b1, 1'b0};
        #1;
        check("single_nobypass_en", 64'(rob_if.en), 64'(0));
        tick();
        dec_valid = 1'b0;
        #1;
        check("single_en", 64'(rob_if.en), 64'(2'b11));
        check("single_disp_valid", 64'(disp_valid), 64'(2'b11));
        check("single_tag", 64'(disp_rob_addr), 64'({6'd6, 6'd5}));
        check("single_bank", 64'(disp_bank_addr), 64'(2'b10));
        check("single_pc", {rob_if.lane[0].pc, rob_if.lane[1].pc}, {32'h100, 32'h104});
        tick();
        #1;
        check("single_drained_en", 64'(rob_if.en), 64'(0));
        check("single_drained_ready", 64'(dec_ready), 64'(1));

        // Streaming at count=1: one push and one pop every cycle.
        dec_valid = 1'b1;
        dec_lane  = mk_grp(32'h1000, 2'b11);
        tick();
        for (int k = 1; k <= 10; k++) begin
            dec_lane = mk_grp(32'h1000 + 32'(k * 16), 2'b11);
            #1;
            check($sformatf("stream%0d_en", k), 64'(rob_if.en), 64'(2'b11));
            check($sformatf("stream%0d_pc", k), 64'(rob_if.lane[0].pc), 64'(32'h1000 + 32'((k - 1) * 16)));
            check($sformatf("stream%0d_ready", k), 64'(dec_ready), 64'(1));
            tick();
        end
        dec_valid = 1'b0;
        #1;
        check("stream_last_pc", 64'(rob_if.lane[0].pc), 64'(32'h1000 + 32'(10 * 16)));
        check("stream_last_en", 64'(rob_if.en), 64'(2'b11));
        tick();
        #1;
        check("stream_empty_en", 64'(rob_if.en), 64'(0));

        // Directed table: full/hold, partial and all-invalid groups, flush.
        for (int v = 0; v < 16; v++) begin
            dec_valid   = vecs[v].dv;
            dec_lane    = mk_grp(vecs[v].pc, vecs[v].lv);
            rob_if.full = vecs[v].full;
            flush       = vecs[v].fl;
            #1;
            check($sformatf("vec%0d_ready", v), 64'(dec_ready), 64'(vecs[v].exp_ready));
            check($sformatf("vec%0d_en", v), 64'(rob_if.en), 64'(vecs[v].exp_en));
            check($sformatf("vec%0d_disp_valid", v), 64'(disp_valid), 64'(vecs[v].exp_en));
            if (vecs[v].chk_pc) begin
                check($sformatf("vec%0d_pc", v), 64'(rob_if.lane[0].pc), 64'(vecs[v].exp_pc));
            end
            tick();
        end
        flush = 1'b0;

        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_cycle(c);
        end

`ifdef ROB_DISPATCH_PERF_EN
        do_reset();
        #1;
        check("perf_rst_stall", 64'(perf_stall_cycles), 64'(0));
        check("perf_rst_disp", 64'(perf_dispatched), 64'(0));
        rob_if.full = 1'b1;
        dec_valid   = 1'b1;
        dec_lane    = mk_grp(32'hA00, 2'b11);
        tick();
        dec_lane    = mk_grp(32'hB00, 2'b11);
        tick();
        dec_valid   = 1'b0;
        tick();
        tick();
        tick();
        rob_if.full = 1'b0;
        tick();
        tick();
        check("perf_stall", 64'(perf_stall_cycles), 64'(4));
        check("perf_disp", 64'(perf_dispatched), 64'(4));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rob_dispatch_ctrl.md
Name: rob_dispatch_ctrl

Overview:
- Dispatch sequencer between rename/decode and the ROB dispatch port.
- Buffers up to two dispatch groups in a small group FIFO and presents the head group to the ROB whenever the ROB is not full.
- Returns the ROB-allocated tags to the issue stage and drops all buffered groups on a pipeline flush.
- Drives the ROB through the robDispatchIf.out modport.

Parameters:
- GROUP_DEPTH, 2, number of buffered dispatch groups; power of two, minimum 2.
- DISPATCH_WIDTH, ROB_ADDR_WIDTH, PHYS_REGS_ADDR_WIDTH, DISPATCH_ADDR_WIDTH: taken from the parameters package, not overridable.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush (mispredict or exception).
- dec_valid  input  1  decode group valid.
- dec_ready  output  1  controller can accept a group this cycle.
- dec_lane  input  DISPATCH_WIDTH x dispatch_lane_t  per-lane fields: valid, phys_rd, arch_rd, is_branch_instr, pred_taken, br_offset[12:0], pc[31:0], instr[31:0].
- rob  interface  robDispatchIf.out  ROB dispatch port (en, fields out; rob_addr, bank_addr, full in).
- disp_valid  output  DISPATCH_WIDTH  lane dispatched this cycle.
- disp_rob_addr  output  DISPATCH_WIDTH x ROB_ADDR_WIDTH  ROB tag per dispatched lane.
- disp_bank_addr  output  DISPATCH_WIDTH x DISPATCH_ADDR_WIDTH  ROB bank per dispatched lane.

Behaviour:
- Reset: FIFO count=0, head/tail pointers=0, all lane valids cleared. Consequently rob.en=0, disp_valid=0, dec_ready=1 in the cycle after reset. All field outputs are 0.
- Push:
  - push = dec_valid && dec_ready.
  - dec_ready = (count != GROUP_DEPTH), decoded from registered state only, with no combinational path from rob.full.
  - The group is written at the tail and the tail increments, wrapping modulo GROUP_DEPTH.
- Head presentation:
  - All rob field outputs are driven combinationally from the head entry.
  - rob.en[i] = head_valid && lane_valid[i] && !rob.full && !flush, where head_valid = (count != 0).
- Pop:
  - fire = head_valid && !rob.full && !flush.
  - On fire the head increments; latency is 0 cycles from head-valid to ROB enable.
  - An accepted group reaches the ROB at the earliest on the cycle after push (1-cycle minimum latency).
- Tag return:
  - disp_valid[i] = rob.en[i].
  - disp_rob_addr[i] = rob.rob_addr[i] and disp_bank_addr[i] = rob.bank_addr[i], passed combinationally in the same cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: count=GROUP_DEPTH forces dec_ready=0. A pop in that cycle does not enable a same-cycle push.
- Empty: no ROB enables, even if dec_valid=1 (no bypass).
- ROB full: the head is held and fields stay stable; it dispatches on the first cycle rob.full=0.
- Flush:
  - Highest priority. In the flush cycle rob.en=0 and no push or pop happens.
  - Next cycle count=0, head=tail, and dec_ready=1.
  - A group presented together with flush is discarded.
- Lane validity: a group with all lanes invalid is still accepted and popped as a no-op (rob.en all 0). Lanes are dispatched as presented; compaction is not required.
- State summary: count in {0..GROUP_DEPTH}; EMPTY / PARTIAL / FULL are derived from count, with no separate FSM register.

Optional Feature:
- ROB_DISPATCH_PERF_EN defined: adds two output ports, both 32-bit saturating counters, reset to 0 by rst and not cleared by flush.
  - perf_stall_cycles: increments when head_valid && rob.full.
  - perf_dispatched: adds popcount(rob.en).
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Parameters package gains the typedef dispatch_lane_t (packed struct holding the lane fields) and the constant GROUP_DEPTH_DEFAULT=2.
- The existing DISPATCH_WIDTH and ROB width constants are reused.
- One sub-module, dispatch_group_fifo: storage, pointers, count and flush clear. rob_dispatch_ctrl owns the handshake, enables and tag return.

Test Plan (DISPATCH_WIDTH=2):
- Reset then single group (pc 0x100/0x104, both valid), rob.full=0, rob_addr {5,6} -> next cycle rob.en=11, disp_rob_addr={5,6}, count returns to 0.
- rob.full=1 held, push 3 groups back-to-back -> dec_ready=0 after the second group is accepted. Release full: groups dispatch on consecutive cycles in order, pcs unchanged.
- Simultaneous push and pop at count=1 with rob.full=0 for 10 cycles -> count stays 1, one group dispatched per cycle, no gaps.
- Partial group (lane0 valid, lane1 invalid, instr 0x00000013) -> rob.en=01, disp_valid=01.
- Flush with count=2 and dec_valid=1 -> flush cycle rob.en=00. Next cycle count=0, dec_ready=1, and the flushed groups never appear on the ROB.
- With ROB_DISPATCH_PERF_EN: 4 cycles of rob.full followed by dispatch of 2 full groups -> perf_stall_cycles=4, perf_dispatched=4.
